seg7_scan_driver: RTL and testbench

Parametrised multi-digit seven-segment display driver. It holds a tear-free `NUM_DIGITS`-digit hexadecimal value and time-multiplexes it onto one shared segment bus with one-hot digit enables. It sits between datapath result registers (GCD/factorisation results) and the board display pins, and supersedes per-digit combinational decoding.

---
 rtl/seg7_pkg.sv | 43 ++++
 rtl/seg7_lz_mask.sv | 21 ++
 rtl/seg7_scan_driver.sv | 122 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: active-high seven-segment font constants ({g,f,e,d,c,b,a}) and hex font lookup.
package seg7_pkg;

   localparam logic [6:0] SEG7_0   = 7'b0111111;
   localparam logic [6:0] SEG7_1   = 7'b0000110;
   localparam logic [6:0] SEG7_2   = 7'b1011011;
   localparam logic [6:0] SEG7_3   = 7'b1001111;
   localparam logic [6:0] SEG7_4   = 7'b1100110;
   localparam logic [6:0] SEG7_5   = 7'b1101101;
   localparam logic [6:0] SEG7_6   = 7'b1111101;
   localparam logic [6:0] SEG7_7   = 7'b0000111;
   localparam logic [6:0] SEG7_8   = 7'b1111111;
   localparam logic [6:0] SEG7_9   = 7'b1101111;
   localparam logic [6:0] SEG7_A   = 7'b1110111;
   localparam logic [6:0] SEG7_B   = 7'b1111100;
   localparam logic [6:0] SEG7_C   = 7'b0111001;
   localparam logic [6:0] SEG7_D   = 7'b1011110;
   localparam logic [6:0] SEG7_E   = 7'b1111001;
   localparam logic [6:0] SEG7_F   = 7'b1110001;
   localparam logic [6:0] SEG7_OFF = 7'b0000000;

   function automatic logic [6:0] seg7_font(input logic [3:0] nibble);
      case (nibble)
         4'h0: return SEG7_0;
         4'h1: return SEG7_1;
         4'h2: return SEG7_2;
         4'h3: return SEG7_3;
         4'h4: return SEG7_4;
         4'h5: return SEG7_5;
         4'h6: return SEG7_6;
         4'h7: return SEG7_7;
         4'h8: return SEG7_8;
         4'h9: return SEG7_9;
         4'hA: return SEG7_A;
         4'hB: return SEG7_B;
         4'hC: return SEG7_C;
         4'hD: return SEG7_D;
         4'hE: return SEG7_E;
         default: return SEG7_F;
      endcase
   endfunction

endpackage

// File: rtl/seg7_lz_mask.sv
// seg7_lz_mask: per-digit leading-zero suppression mask; bit i set when digit i and all above are zero.
module seg7_lz_mask #(
   parameter int NUM_DIGITS = 4
) (
   input  logic [4*NUM_DIGITS-1:0] value,
   output logic [NUM_DIGITS-1:0]   mask
);

   logic zero_above;

   // Walk down from the top digit; digit 0 is never suppressed.
   always_comb begin
      zero_above = 1'b1;
      mask = '0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         zero_above = zero_above && (value[4*i +: 4] == 4'h0);
         mask[i] = zero_above;
      end
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: tear-free multiplexed hex display driver with frame-aligned commit of loaded values.
// Optional leading-zero suppression is compiled in with `define SEG7_LZ_BLANK_EN.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int SCAN_DIV       = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    load,
   input  logic                    blank,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    pending,
   output logic                    frame_done
);

   localparam int DIV_W = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [6:0] SEG_OFF_LVL = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic DP_OFF_LVL = SEG_ACTIVE_LOW;
   localparam logic [NUM_DIGITS-1:0] AN_OFF_LVL = AN_ACTIVE_LOW ? '1 : '0;

   logic [DIV_W-1:0]        div_q, div_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d, disp_val_q, disp_val_d;
   logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d, disp_dp_q, disp_dp_d;
   logic                    pending_q, pending_d, frame_done_q, frame_done_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic                    tick, boundary;
   logic [NUM_DIGITS-1:0]   sup, an_raw;
   logic [3:0]              nib;
   logic                    dp_sel, sup_sel;
   logic [6:0]              seg_raw;

`ifdef SEG7_LZ_BLANK_EN
   seg7_lz_mask #(.NUM_DIGITS(NUM_DIGITS)) u_lz_mask (
      .value (disp_val_q),
      .mask  (sup)
   );
`else
   assign sup = '0;
`endif

   // A load coinciding with the frame boundary bypasses the shadow entirely.
   always_comb begin
      tick = div_q == DIV_MAX;
      boundary = tick && idx_q == IDX_MAX;
      div_d = tick ? '0 : div_q + 1'b1;
      idx_d = !tick ? idx_q : boundary ? '0 : idx_q + 1'b1;
      shadow_val_d = load ? value_in : shadow_val_q;
      shadow_dp_d = load ? dp_in : shadow_dp_q;
      disp_val_d = boundary && load ? value_in : boundary && pending_q ? shadow_val_q : disp_val_q;
      disp_dp_d = boundary && load ? dp_in : boundary && pending_q ? shadow_dp_q : disp_dp_q;
      pending_d = boundary ? 1'b0 : load | pending_q;
      frame_done_d = boundary;
   end

   always_comb begin
      nib = 4'h0;
      dp_sel = 1'b0;
      sup_sel = 1'b0;
      an_raw = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            nib = disp_val_q[4*i +: 4];
            dp_sel = disp_dp_q[i];
            sup_sel = sup[i];
            an_raw[i] = 1'b1;
         end
      end
      seg_raw = sup_sel ? SEG7_OFF : seg7_font(nib);
      seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
      dp_d = SEG_ACTIVE_LOW ? ~dp_sel : dp_sel;
      an_d = blank ? AN_OFF_LVL : AN_ACTIVE_LOW ? ~an_raw : an_raw;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_q <= '0;
         idx_q <= '0;
         shadow_val_q <= '0;
         shadow_dp_q <= '0;
         disp_val_q <= '0;
         disp_dp_q <= '0;
         pending_q <= 1'b0;
         frame_done_q <= 1'b0;
         seg_q <= SEG_OFF_LVL;
         dp_q <= DP_OFF_LVL;
         an_q <= AN_OFF_LVL;
      end else begin
         div_q <= div_d;
         idx_q <= idx_d;
         shadow_val_q <= shadow_val_d;
         shadow_dp_q <= shadow_dp_d;
         disp_val_q <= disp_val_d;
         disp_dp_q <= disp_dp_d;
         pending_q <= pending_d;
         frame_done_q <= frame_done_d;
         seg_q <= seg_d;
         dp_q <= dp_d;
         an_q <= an_d;
      end
   end

   assign seg = seg_q;
   assign dp = dp_q;
   assign an = an_q;
   assign pending = pending_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized self-checking bench; the reference model derives digit position
// and frame boundaries from the cycle count since reset with plain arithmetic.
module tb_seg7_scan_driver;

   localparam int N = 4;
   localparam int D = 4;
   localparam int F = N * D;
   localparam logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        load = 1'b0;
   logic        blank = 1'b0;
   logic [15:0] value_in = '0;
   logic [3:0]  dp_in = '0;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  an;
   logic        pending, frame_done;

   int chk = 0;
   int pass_n = 0;

   int          t;
   logic [15:0] m_disp, m_shad;
   logic [3:0]  m_dpd, m_dps;
   logic        m_pend;
   logic [6:0]  e_seg;
   logic        e_dp;
   logic [3:0]  e_an;
   logic        e_pend, e_fd;

   always #5 clk = ~clk;

   seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(D), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut (
      .clk        (clk),
      .reset      (reset),
      .value_in   (value_in),
      .dp_in      (dp_in),
      .load       (load),
      .blank      (blank),
      .seg        (seg),
      .dp         (dp),
      .an         (an),
      .pending    (pending),
      .frame_done (frame_done)
   );

   task automatic model_reset();
      t = 0;
      m_disp = '0;
      m_shad = '0;
      m_dpd = '0;
      m_dps = '0;
      m_pend = 1'b0;
      e_seg = 7'h7F;
      e_dp = 1'b1;
      e_an = 4'hF;
      e_pend = 1'b0;
      e_fd = 1'b0;
   endtask

   // Predict the outputs after the coming edge from the state before it, then take the edge.
   task automatic step();
      int idx, h;
      bit bnd;
      logic [6:0] raw;
      logic [3:0] oh;
      idx = (t / D) % N;
      bnd = (t % F) == F - 1;
      h = -1;
      for (int i = 0; i < N; i++) if (m_disp[4*i +: 4] != 4'h0) h = i;
      raw = FONT[m_disp[4*idx +: 4]];
`ifdef SEG7_LZ_BLANK_EN
      if (idx > 0 && idx > h) raw = 7'h00;
`endif
      oh = 4'b0001 << idx;
      e_seg = ~raw;
      e_dp = ~m_dpd[idx];
      e_an = blank ? 4'hF : ~oh;
      e_fd = bnd;
      e_pend = bnd ? 1'b0 : (load | m_pend);
      if (bnd && load) begin
         m_disp = value_in;
         m_dpd = dp_in;
      end else if (bnd && m_pend) begin
         m_disp = m_shad;
         m_dpd = m_dps;
      end
      if (load) begin
         m_shad = value_in;
         m_dps = dp_in;
      end
      m_pend = e_pend;
      t++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk++;
      if ({seg, dp, an, pending, frame_done} !== {7'h7F, 1'b1, 4'hF, 1'b0, 1'b0})
         $display("FAIL reset_hold seg=%b dp=%b an=%b pend=%b fd=%b", seg, dp, an, pending, frame_done);
      else pass_n++;
      reset = 1'b0;
      step();
      chk++;
      if (an !== 4'b1110 || seg !== 7'b1000000)
         $display("FAIL reset_first_digit an=%b (want 1110) seg=%b (want 1000000)", an, seg);
      else pass_n++;
      repeat (F) begin
         step();
         chk++;
         if ({seg, dp, an, pending, frame_done} !== {e_seg, e_dp, e_an, e_pend, e_fd})
            $display("FAIL reset_scan t=%0d seg=%b/%b dp=%b/%b an=%b/%b pend=%b/%b fd=%b/%b",
                     t, seg, e_seg, dp, e_dp, an, e_an, pending, e_pend, frame_done, e_fd);
         else pass_n++;
      end
   endtask

   task automatic test_load_mid();
      while (t % F != 5) step();
      value_in = 16'h12AF;
      dp_in = 4'($urandom);
      load = 1'b1;
      step();
      load = 1'b0;
      chk++;
      if (pending !== 1'b1) $display("FAIL load_mid_pending got=%b want=1", pending);
      else pass_n++;
      repeat (3 * F) begin
         value_in = 16'($urandom);
         step();
         chk++;
         if ({seg, dp, an, pending, frame_done} !== {e_seg, e_dp, e_an, e_pend, e_fd})
            $display("FAIL load_mid t=%0d seg=%b/%b dp=%b/%b an=%b/%b pend=%b/%b fd=%b/%b",
                     t, seg, e_seg, dp, e_dp, an, e_an, pending, e_pend, frame_done, e_fd);
         else pass_n++;
      end
   endtask

   task automatic test_boundary_load();
      while (t % F != F - 1) step();
      value_in = 16'($urandom);
      dp_in = 4'($urandom);
      load = 1'b1;
      step();
      load = 1'b0;
      chk++;
      if (pending !== 1'b0) $display("FAIL boundary_pending got=%b want=0", pending);
      else pass_n++;
      step();
      chk++;
      if ({seg, dp, an} !== {e_seg, e_dp, e_an})
         $display("FAIL boundary_digit0 seg=%b/%b dp=%b/%b an=%b/%b", seg, e_seg, dp, e_dp, an, e_an);
      else pass_n++;
      while (t % F != 3) step();
      value_in = 16'h3C3C;
      load = 1'b1;
      step();
      value_in = 16'hBEEF;
      dp_in = 4'($urandom);
      step();
      load = 1'b0;
      repeat (2 * F) begin
         step();
         chk++;
         if ({seg, dp, an, pending, frame_done} !== {e_seg, e_dp, e_an, e_pend, e_fd})
            $display("FAIL double_load t=%0d seg=%b/%b dp=%b/%b an=%b/%b pend=%b/%b fd=%b/%b",
                     t, seg, e_seg, dp, e_dp, an, e_an, pending, e_pend, frame_done, e_fd);
         else pass_n++;
      end
   endtask

   task automatic test_lz();
      value_in = 16'h0050;
      dp_in = 4'b0000;
      load = 1'b1;
      step();
      load = 1'b0;
      repeat (2 * F) begin
         step();
         chk++;
         if ({seg, dp, an, pending, frame_done} !== {e_seg, e_dp, e_an, e_pend, e_fd})
            $display("FAIL lz t=%0d seg=%b/%b dp=%b/%b an=%b/%b pend=%b/%b fd=%b/%b",
                     t, seg, e_seg, dp, e_dp, an, e_an, pending, e_pend, frame_done, e_fd);
         else pass_n++;
      end
   endtask

   task automatic test_blank();
      blank = 1'b1;
      repeat (10) begin
         step();
         chk++;
         if ({seg, dp, an, pending, frame_done} !== {e_seg, e_dp, e_an, e_pend, e_fd})
            $display("FAIL blank t=%0d seg=%b/%b dp=%b/%b an=%b/%b pend=%b/%b fd=%b/%b",
                     t, seg, e_seg, dp, e_dp, an, e_an, pending, e_pend, frame_done, e_fd);
         else pass_n++;
      end
      blank = 1'b0;
      repeat (F) begin
         step();
         chk++;
         if ({seg, dp, an, pending, frame_done} !== {e_seg, e_dp, e_an, e_pend, e_fd})
            $display("FAIL unblank t=%0d seg=%b/%b dp=%b/%b an=%b/%b pend=%b/%b fd=%b/%b",
                     t, seg, e_seg, dp, e_dp, an, e_an, pending, e_pend, frame_done, e_fd);
         else pass_n++;
      end
   endtask

   task automatic test_random();
      repeat (400) begin
         load = $urandom_range(0, 9) == 0;
         value_in = 16'($urandom);
         dp_in = 4'($urandom);
         blank = $urandom_range(0, 7) == 0;
         step();
         chk++;
         if ({seg, dp, an, pending, frame_done} !== {e_seg, e_dp, e_an, e_pend, e_fd})
            $display("FAIL random t=%0d seg=%b/%b dp=%b/%b an=%b/%b pend=%b/%b fd=%b/%b",
                     t, seg, e_seg, dp, e_dp, an, e_an, pending, e_pend, frame_done, e_fd);
         else pass_n++;
      end
      load = 1'b0;
      blank = 1'b0;
   endtask

   task automatic test_reset_mid();
      while (t % F != 6) step();
      value_in = 16'h9876;
      dp_in = 4'b1010;
      load = 1'b1;
      step();
      load = 1'b0;
      chk++;
      if (pending !== 1'b1) $display("FAIL reset_mid_pending_pre got=%b want=1", pending);
      else pass_n++;
      #2;
      reset = 1'b1;
      #1;
      chk++;
      if ({seg, dp, an, pending, frame_done} !== {7'h7F, 1'b1, 4'hF, 1'b0, 1'b0})
         $display("FAIL reset_mid_async seg=%b dp=%b an=%b pend=%b fd=%b", seg, dp, an, pending, frame_done);
      else pass_n++;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      repeat (2 * F) begin
         step();
         chk++;
         if ({seg, dp, an, pending, frame_done} !== {e_seg, e_dp, e_an, e_pend, e_fd})
            $display("FAIL reset_mid_after t=%0d seg=%b/%b dp=%b/%b an=%b/%b pend=%b/%b fd=%b/%b",
                     t, seg, e_seg, dp, e_dp, an, e_an, pending, e_pend, frame_done, e_fd);
         else pass_n++;
      end
   endtask

   initial begin
      test_reset();
      test_load_mid();
      test_boundary_load();
      test_lz();
      test_blank();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_n, chk);
      $finish;
   end

endmodule
